// File: rtl/demux1to2_5bits_buffered_pkg.sv
// ----------------------------------------------------------------------------
// demux1to2_5bits_buffered_pkg
//  Definitions shared by the 1:2 buffered demux and its output FIFO.
//  The width and select encodings match the 2:1 mux family so that words
//  routed onto the shared bus by the mux come back out on the same channel.
// ----------------------------------------------------------------------------
package demux1to2_5bits_buffered_pkg;

   // Bus width shared with the Mux2to1_5bits family.
   localparam int MUX_WIDTH = 5;

   // in_sel encodings: which output a word is steered to.
   localparam logic SEL_OUT0 = 1'b0;
   localparam logic SEL_OUT1 = 1'b1;

   // Number of output channels.
   localparam int NUM_OUT = 2;

   // Status of one output FIFO, grouped for readability in the top level.
   typedef struct packed {
      logic full;
      logic empty;
   } fifo_stat_t;

endpackage : demux1to2_5bits_buffered_pkg

// File: rtl/demux_out_fifo.sv
// ----------------------------------------------------------------------------
// demux_out_fifo
//  Small synchronous first-word-fall-through FIFO used on each demux output.
//  Ports:
//    clock     in   rising-edge clock
//    reset     in   asynchronous, active-high reset
//    push      in   write data_in (ignored when full)
//    pop       in   remove head word (ignored when empty)
//    data_in   in   WIDTH word to write
//    data_out  out  head word; holds the last popped word while empty
//    full      out  occupancy == DEPTH
//    empty     out  occupancy == 0
//  DEPTH must be a power of 2 and >= 2 so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module demux_out_fifo
   import demux1to2_5bits_buffered_pkg::*;
#(
   parameter int WIDTH = MUX_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [AW:0]      occ;
   logic [WIDTH-1:0] last_q;   // last popped word, shown while empty
   logic             do_push;
   logic             do_pop;

   assign full    = (occ == (AW+1)'(DEPTH));
   assign empty   = (occ == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Storage carries no reset; it is never visible while empty.
   always_ff @(posedge clock) begin
      if (do_push) mem[wptr] <= data_in;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wptr   <= '0;
         rptr   <= '0;
         occ    <= '0;
         last_q <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop) begin
            rptr   <= rptr + 1'b1;
            last_q <= mem[rptr];
         end
         // Simultaneous push and pop leaves occupancy unchanged.
         case ({do_push, do_pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   // Fall-through head; after draining, keep presenting the last word so
   // the output bus does not toggle on stale storage.
   assign data_out = empty ? last_q : mem[rptr];

endmodule : demux_out_fifo

// File: rtl/demux1to2_5bits_buffered.sv
// ----------------------------------------------------------------------------
// demux1to2_5bits_buffered
//  Steers one WIDTH-bit input stream to one of two output streams, chosen per
//  word by in_sel. Each output has its own FIFO so a stalled consumer on one
//  side never blocks the other side.
//  Ports:
//    clock, reset            rising-edge clock, async active-high reset
//    in_data/in_sel/in_valid input word, destination select, valid
//    in_ready                selected output FIFO has room
//    outX_data/valid/ready   per-output FWFT stream (X = 0, 1)
//    count0/count1           words accepted per output, wraps mod 2^CNTW
// ----------------------------------------------------------------------------
module demux1to2_5bits_buffered
   import demux1to2_5bits_buffered_pkg::*;
#(
   parameter int WIDTH = MUX_WIDTH,
   parameter int DEPTH = 4,
   parameter int CNTW  = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [CNTW-1:0]  count0,
   output logic [CNTW-1:0]  count1
);

   fifo_stat_t [NUM_OUT-1:0]            stat;
   logic       [NUM_OUT-1:0]            push_en;
   logic       [NUM_OUT-1:0]            pop_en;
   logic       [NUM_OUT-1:0]            fifo_full;
   logic       [NUM_OUT-1:0]            fifo_empty;
   logic       [NUM_OUT-1:0][WIDTH-1:0] fifo_dout;
   logic       [NUM_OUT-1:0][CNTW-1:0]  cnt;
   logic                                accept;

   // Ready depends only on the selected FIFO, never on in_valid or on the
   // other FIFO; a full FIFO refuses a push even if it pops this cycle.
   assign in_ready = ~fifo_full[in_sel];
   assign accept   = in_valid & in_ready;

   assign pop_en[SEL_OUT0] = out0_ready & ~fifo_empty[SEL_OUT0];
   assign pop_en[SEL_OUT1] = out1_ready & ~fifo_empty[SEL_OUT1];

   for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
      // in_valid gates the decode so an undriven in_sel while idle is harmless.
      assign push_en[g]    = accept & (in_sel == 1'(g));
      assign fifo_full[g]  = stat[g].full;
      assign fifo_empty[g] = stat[g].empty;

      demux_out_fifo #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clock    (clock),
         .reset    (reset),
         .push     (push_en[g]),
         .pop      (pop_en[g]),
         .data_in  (in_data),
         .data_out (fifo_dout[g]),
         .full     (stat[g].full),
         .empty    (stat[g].empty)
      );

      always_ff @(posedge clock or posedge reset) begin
         if (reset)           cnt[g] <= '0;
         else if (push_en[g]) cnt[g] <= cnt[g] + 1'b1;
      end
   end

   assign out0_data  = fifo_dout[SEL_OUT0];
   assign out0_valid = ~fifo_empty[SEL_OUT0];
   assign out1_data  = fifo_dout[SEL_OUT1];
   assign out1_valid = ~fifo_empty[SEL_OUT1];
   assign count0     = cnt[SEL_OUT0];
   assign count1     = cnt[SEL_OUT1];

endmodule : demux1to2_5bits_buffered
